// File: rtl/ans_to_str.sv
// ans_to_str: converts a 32-bit calculator result into a packed ASCII string.
// The string is MSB byte first, terminated and padded with "\n" (8'h0A).
// Conversion is a 32-step double-dabble, then one digit is packed per cycle
// with leading zeros suppressed. Latency is a fixed 43 edges from start to done.
module ans_to_str #(
    parameter int STR_BYTES = 32,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            value,
    output logic                   busy,
    output logic                   done,
    output logic [8*STR_BYTES-1:0] str
);

    localparam logic [8*STR_BYTES-1:0] FILL = {STR_BYTES{8'h0A}};

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        PACK,
        FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            mag_q, mag_d;     // magnitude always fits in 32 bits
    logic [39:0]            bcd_q, bcd_d;     // ten BCD digits, digit 0 in [3:0]
    logic [3:0]             ptr_q, ptr_d;     // next byte position to write
    logic [4:0]             cnt_q, cnt_d;     // CONV step count, then PACK digit index
    logic                   seen_q, seen_d;   // a significant digit has been written
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [8*STR_BYTES-1:0] str_q, str_d;

    // Per-step scratch values used by the datapath process.
    logic                   neg;
    logic [39:0]            adj;
    logic [3:0]             digit;

    // State and datapath registers; everything returns to its idle value on reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            str_q   <= FILL;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            str_q   <= str_d;
        end
    end

    // Next-state selection: fixed-length CONV and PACK phases, two-cycle FIN.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (cnt_q == 5'd31) state_d = PACK;
            PACK:    if (cnt_q == 5'd0) state_d = FIN;
            FIN:     if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output register updates for the current state.
    always_comb begin
        mag_d  = mag_q;
        bcd_d  = bcd_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        seen_d = seen_q;
        busy_d = busy_q;
        done_d = done_q;
        str_d  = str_q;
        neg    = 1'b0;
        adj    = bcd_q;
        digit  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg    = SIGNED && value[31];
                    // 32-bit negation maps 32'h80000000 onto 2147483648 unsigned.
                    mag_d  = neg ? (~value + 32'd1) : value;
                    bcd_d  = '0;
                    cnt_d  = '0;
                    seen_d = 1'b0;
                    busy_d = 1'b1;
                    str_d  = FILL;
                    ptr_d  = '0;
                    if (neg) begin
                        str_d[8*STR_BYTES-1 -: 8] = 8'h2D;
                        ptr_d                     = 4'd1;
                    end
                end
            end
            CONV: begin
                for (int i = 0; i < 10; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                {bcd_d, mag_d} = {adj, mag_q} << 1;
                cnt_d = (cnt_q == 5'd31) ? 5'd9 : cnt_q + 5'd1;
            end
            PACK: begin
                digit = bcd_q[4*cnt_q +: 4];
                // Digit 0 is always written so a zero result still prints "0".
                if (digit != 4'd0 || seen_q || cnt_q == 5'd0) begin
                    str_d[8*(STR_BYTES-1-int'(ptr_q)) +: 8] = {4'h3, digit};
                    ptr_d  = ptr_q + 4'd1;
                    seen_d = 1'b1;
                end
                cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
            end
            FIN: begin
                if (!done_q) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        busy = busy_q;
        done = done_q;
        str  = str_q;
    end

endmodule
